// File: rtl/wall_registry_pkg.sv
// Shared types and constants for the wall registry: coordinate width, tile size,
// FSM state encoding and the layout of one wall slot.
package wall_registry_pkg;

   localparam int COORD_W      = 11;
   localparam int TILE_SIZE_PX = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      CHECK  = 2'd2,
      COMMIT = 2'd3
   } wall_state_t;

   typedef struct packed {
      logic               valid;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } wall_slot_t;

endpackage

// File: rtl/wall_registry_if.sv
// Spawn handshake between the game controller (master) and the wall registry (slave).
interface wall_registry_if;
   import wall_registry_pkg::*;

   logic               spawn_req;
   logic [COORD_W-1:0] cand_x;
   logic [COORD_W-1:0] cand_y;
   logic               busy;
   logic               spawn_done;
   logic               spawn_fail;
   logic [4:0]         wall_count;

   modport master (
      output spawn_req, cand_x, cand_y,
      input  busy, spawn_done, spawn_fail, wall_count
   );

   modport slave (
      input  spawn_req, cand_x, cand_y,
      output busy, spawn_done, spawn_fail, wall_count
   );

endinterface

// File: rtl/wall_registry_tile_match.sv
// Per-slot comparator: does the head origin equal this wall, and does the
// current VGA pixel fall inside this wall's tile.
module wall_tile_match
   import wall_registry_pkg::*;
#(
   parameter int TILE_SIZE = TILE_SIZE_PX
) (
   input  wall_slot_t         slot,
   input  logic [COORD_W-1:0] head_x,
   input  logic [COORD_W-1:0] head_y,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   output logic               head_eq,
   output logic               pix_in
);

   localparam logic [COORD_W:0] TILE_EXT = (COORD_W + 1)'(TILE_SIZE);

   // One extra bit on the far edge so tiles near 2047 do not wrap to 0.
   logic [COORD_W:0] x_end;
   logic [COORD_W:0] y_end;

   assign x_end = {1'b0, slot.x} + TILE_EXT;
   assign y_end = {1'b0, slot.y} + TILE_EXT;

   assign head_eq = slot.valid && (slot.x == head_x) && (slot.y == head_y);

   assign pix_in = slot.valid
                && (pix_x >= slot.x) && ({1'b0, pix_x} < x_end)
                && (pix_y >= slot.y) && ({1'b0, pix_y} < y_end);

endmodule

// File: rtl/wall_registry.sv
// Accepts wall candidates from the generator, rejects overlaps, keeps accepted
// walls in a ring, and reports head collisions and per-pixel wall coverage.
module wall_registry
   import wall_registry_pkg::*;
#(
   parameter int NUM_WALLS = 8,
   parameter int TILE_SIZE = TILE_SIZE_PX,
   parameter int MAX_RETRY = 4
) (
   input  logic               clk,
   input  logic               btnrst,
   wall_registry_if.slave     bus,
   input  logic [COORD_W-1:0] snakehead_x,
   input  logic [COORD_W-1:0] snakehead_y,
   input  logic [COORD_W-1:0] draw_x,
   input  logic [COORD_W-1:0] draw_y,
   output logic               hit,
   output logic               wall_on
);

   localparam int IDX_W = $clog2(NUM_WALLS);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   wall_state_t        state_q, state_d;
   wall_slot_t         slot_q [NUM_WALLS];
   wall_slot_t         slot_d [NUM_WALLS];
   logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
   logic [IDX_W-1:0]   idx_q, idx_d, wr_ptr_q, wr_ptr_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic [4:0]         count_q, count_d;
   logic               done_q, done_d, fail_q, fail_d;
   logic               hit_q, hit_d, wall_on_q, wall_on_d;
   logic [NUM_WALLS-1:0] head_eq, pix_in;
   logic               reject;

   for (genvar g = 0; g < NUM_WALLS; g++) begin : g_match
      wall_tile_match #(.TILE_SIZE(TILE_SIZE)) u_match (
         .slot    (slot_q[g]),
         .head_x  (snakehead_x),
         .head_y  (snakehead_y),
         .pix_x   (draw_x),
         .pix_y   (draw_y),
         .head_eq (head_eq[g]),
         .pix_in  (pix_in[g])
      );
   end

   // The head only needs testing once per sample, so it rides on scan index 0.
   assign reject = ((idx_q == '0) && (cx_q == snakehead_x) && (cy_q == snakehead_y))
                || (slot_q[idx_q].valid && (slot_q[idx_q].x == cx_q) && (slot_q[idx_q].y == cy_q));

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      idx_d     = idx_q;
      wr_ptr_d  = wr_ptr_q;
      retry_d   = retry_q;
      count_d   = count_q;
      done_d    = 1'b0;
      fail_d    = 1'b0;
      hit_d     = |head_eq;
      wall_on_d = |pix_in;

      case (state_q)
         IDLE: begin
            if (bus.spawn_req) state_d = SAMPLE;
         end
         SAMPLE: begin
            cx_d    = bus.cand_x;
            cy_d    = bus.cand_y;
            idx_d   = '0;
            state_d = CHECK;
         end
         CHECK: begin
            if (reject) begin
               if (retry_q == RTY_W'(MAX_RETRY - 1)) begin
                  fail_d  = 1'b1;
                  retry_d = '0;
                  state_d = IDLE;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = SAMPLE;
               end
            end else if (idx_q == IDX_W'(NUM_WALLS - 1)) begin
               state_d = COMMIT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         COMMIT: begin
            slot_d[wr_ptr_q] = '{valid: 1'b1, x: cx_q, y: cy_q};
            wr_ptr_d = (wr_ptr_q == IDX_W'(NUM_WALLS - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (count_q != 5'(NUM_WALLS)) count_d = count_q + 5'd1;
            done_d  = 1'b1;
            retry_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge btnrst) begin
      if (btnrst) begin
         state_q   <= IDLE;
         for (int i = 0; i < NUM_WALLS; i++) slot_q[i] <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         idx_q     <= '0;
         wr_ptr_q  <= '0;
         retry_q   <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
         hit_q     <= 1'b0;
         wall_on_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         idx_q     <= idx_d;
         wr_ptr_q  <= wr_ptr_d;
         retry_q   <= retry_d;
         count_q   <= count_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
         hit_q     <= hit_d;
         wall_on_q <= wall_on_d;
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.spawn_done = done_q;
   assign bus.spawn_fail = fail_q;
   assign bus.wall_count = count_q;
   assign hit            = hit_q;
   assign wall_on        = wall_on_q;

endmodule

// File: tb/tb_wall_registry.sv
// Scoreboard bench for wall_registry: spawn outcomes are queued when issued and
// checked by an independent monitor; hit/wall_on are checked directly.
module tb_wall_registry;

   localparam int NW  = 8;
   localparam int LAT_OK = NW + 3;

   logic        clk = 1'b0;
   logic        btnrst = 1'b1;
   logic [10:0] snakehead_x, snakehead_y, draw_x, draw_y;
   logic        hit, wall_on;

   wall_registry_if bus ();

   wall_registry #(.NUM_WALLS(NW), .TILE_SIZE(32), .MAX_RETRY(4)) dut (
      .clk         (clk),
      .btnrst      (btnrst),
      .bus         (bus),
      .snakehead_x (snakehead_x),
      .snakehead_y (snakehead_y),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .hit         (hit),
      .wall_on     (wall_on)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] kind;
      int         count;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: every done/fail pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.spawn_done || bus.spawn_fail) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_pulse: got done=%0b fail=%0b, expected no pulse (t=%0t)",
                     bus.spawn_done, bus.spawn_fail, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("pulse_kind{done,fail}", int'({bus.spawn_done, bus.spawn_fail}), int'(e.kind));
            checkOutput("wall_count_at_pulse", int'(bus.wall_count), e.count);
            checkOutput("pulse_cycle", cyc, e.due);
         end
      end
   end

   // Called just after a rising edge; pulses spawn_req for one cycle.
   task automatic applyStimulus(input logic [10:0] x, input logic [10:0] y, input bit expect_resp,
                                input bit is_fail, input int cnt, input int lat);
      exp_t e;
      bus.cand_x    = x;
      bus.cand_y    = y;
      bus.spawn_req = 1'b1;
      if (expect_resp) begin
         e.kind  = is_fail ? 2'b01 : 2'b10;
         e.count = cnt;
         e.due   = cyc + lat;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.spawn_req = 1'b0;
   endtask

   task automatic waitIdle();
      bit done_ok = 1'b0;
      for (int n = 0; n < 40 && !done_ok; n++) begin
         @(posedge clk); #1;
         if (sb.size() == 0 && !bus.busy) done_ok = 1'b1;
      end
      if (!done_ok) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL wait_idle: got busy=%0b pending=%0d, expected idle within 40 cycles",
                  bus.busy, sb.size());
         sb.delete();
      end
   endtask

   task automatic stepCheck(input string name, input int actual_sel, input int expected);
      @(posedge clk); #1;
      checkOutput(name, actual_sel == 0 ? int'(hit) : int'(wall_on), expected);
   endtask

   initial begin
      bus.spawn_req = 1'b0;
      bus.cand_x    = '0;
      bus.cand_y    = '0;
      snakehead_x   = 11'd400;
      snakehead_y   = 11'd400;
      draw_x        = 11'd1000;
      draw_y        = 11'd1000;

      #12;
      checkOutput("reset_busy", int'(bus.busy), 0);
      checkOutput("reset_done", int'(bus.spawn_done), 0);
      checkOutput("reset_fail", int'(bus.spawn_fail), 0);
      checkOutput("reset_count", int'(bus.wall_count), 0);
      checkOutput("reset_hit", int'(hit), 0);
      checkOutput("reset_wall_on", int'(wall_on), 0);
      #11 btnrst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] accepted spawn at (16,144)");
      applyStimulus(11'd16, 11'd144, 1'b1, 1'b0, 1, LAT_OK);
      waitIdle();

      $display("[TB] head collision tracking");
      checkOutput("hit_far_head", int'(hit), 0);
      snakehead_x = 11'd16; snakehead_y = 11'd144;
      stepCheck("hit_on_wall", 0, 1);
      snakehead_x = 11'd400; snakehead_y = 11'd400;
      stepCheck("hit_after_move", 0, 0);

      $display("[TB] pixel coverage edges");
      draw_x = 11'd47; draw_y = 11'd175; stepCheck("wall_on_47_175", 1, 1);
      draw_x = 11'd48; draw_y = 11'd144; stepCheck("wall_on_48_144", 1, 0);
      draw_x = 11'd15; draw_y = 11'd150; stepCheck("wall_on_15_150", 1, 0);
      draw_x = 11'd16; draw_y = 11'd144; stepCheck("wall_on_16_144", 1, 1);
      draw_x = 11'd20; draw_y = 11'd176; stepCheck("wall_on_20_176", 1, 0);

      $display("[TB] candidate on head, retries exhausted");
      snakehead_x = 11'd80; snakehead_y = 11'd176;
      applyStimulus(11'd80, 11'd176, 1'b1, 1'b1, 1, 9);
      waitIdle();
      checkOutput("busy_after_fail", int'(bus.busy), 0);
      checkOutput("count_after_fail", int'(bus.wall_count), 1);
      snakehead_x = 11'd400; snakehead_y = 11'd400;

      $display("[TB] reset during scan");
      applyStimulus(11'd200, 11'd200, 1'b0, 1'b0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("busy_in_check", int'(bus.busy), 1);
      #2 btnrst = 1'b1;
      #1;
      checkOutput("busy_in_reset", int'(bus.busy), 0);
      checkOutput("count_in_reset", int'(bus.wall_count), 0);
      #3 btnrst = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("busy_after_reset", int'(bus.busy), 0);

      $display("[TB] ring wrap with nine walls");
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(11'(32 * i), 11'd64, 1'b1, 1'b0, (i > NW) ? NW : i, LAT_OK);
         waitIdle();
      end
      checkOutput("count_saturated", int'(bus.wall_count), NW);
      snakehead_x = 11'd32;  snakehead_y = 11'd64; stepCheck("hit_first_overwritten", 0, 0);
      snakehead_x = 11'd288; snakehead_y = 11'd64; stepCheck("hit_ninth_present", 0, 1);
      snakehead_x = 11'd64;  snakehead_y = 11'd64; stepCheck("hit_second_present", 0, 1);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
